// File: rtl/pcpi_muldiv_iter_if.sv
// ---------------------------------------------------------------------------
// pcpi_muldiv_iter_if
// PCPI co-processor bus bundle between the core (master) and an M-extension
// co-processor (slave).
//   pcpi_valid  core -> slave   instruction presented
//   pcpi_insn   core -> slave   32-bit instruction word
//   pcpi_rs1    core -> slave   operand 1 (XLEN)
//   pcpi_rs2    core -> slave   operand 2 (XLEN)
//   pcpi_wr     slave -> core   write-back strobe
//   pcpi_rd     slave -> core   result (XLEN)
//   pcpi_wait   slave -> core   instruction claimed, result pending
//   pcpi_ready  slave -> core   one-cycle completion pulse
// ---------------------------------------------------------------------------
interface pcpi_muldiv_iter_if #(
   parameter int XLEN = 32
);
   logic            pcpi_valid;
   logic [31:0]     pcpi_insn;
   logic [XLEN-1:0] pcpi_rs1;
   logic [XLEN-1:0] pcpi_rs2;
   logic            pcpi_wr;
   logic [XLEN-1:0] pcpi_rd;
   logic            pcpi_wait;
   logic            pcpi_ready;

   modport master (
      output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
      input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
   );

   modport slave (
      input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
      output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
   );
endinterface

// File: rtl/pcpi_muldiv_iter.sv
// ---------------------------------------------------------------------------
// pcpi_muldiv_iter
// Iterative RV32M multiply/divide co-processor on the PCPI bus.
// MUL/MULH/MULHSU/MULHU retire MUL_STEP multiplier bits per cycle; with
// ENABLE_DIV set, DIV/DIVU/REM/REMU run on a 1-bit/cycle restoring divider.
// Every operation spends one extra cycle after its iterations to select and
// sign-fix the result, so ready follows accept by N+1 cycles.
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   pcpi    PCPI slave modport (valid/insn/rs1/rs2 in; wr/rd/wait/ready out)
// Parameters: XLEN (multiple of MUL_STEP), MUL_STEP (1,2,4,8), ENABLE_DIV.
// ---------------------------------------------------------------------------
module pcpi_muldiv_iter #(
   parameter int XLEN       = 32,
   parameter int MUL_STEP   = 4,
   parameter int ENABLE_DIV = 1
) (
   input  logic              clk,
   input  logic              resetn,
   pcpi_muldiv_iter_if.slave pcpi
);
   localparam int MUL_N = XLEN / MUL_STEP;
   localparam int CNT_W = $clog2(XLEN + 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t           state;
   logic             armed;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       f3;
   logic             ready_q;
   logic             wait_q;
   logic [XLEN-1:0]  rd_q;

   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] mcand;
   logic [XLEN-1:0]   mplier;
   logic              b_neg;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   dvsr;
   logic              q_neg;
   logic              r_neg;
   logic              dvsr_zero;

   function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   // Sum of the multiplicand shifted by each set bit of one multiplier chunk.
   function automatic logic [2*XLEN-1:0] mul_chunk(input logic [2*XLEN-1:0] a,
                                                   input logic [MUL_STEP-1:0] b);
      logic [2*XLEN-1:0] sum;
      sum = '0;
      for (int j = 0; j < MUL_STEP; j++)
         if (b[j]) sum = sum + (a << j);
      return sum;
   endfunction

   logic [31:0]     insn;
   logic [XLEN-1:0] rs1, rs2;
   logic [2:0]      f3_in;
   logic            is_m, is_mul, is_div, accept;
   logic            a_sx, b_sx, div_sgn;
   logic            unused_insn;

   assign insn    = pcpi.pcpi_insn;
   assign rs1     = pcpi.pcpi_rs1;
   assign rs2     = pcpi.pcpi_rs2;
   assign f3_in   = insn[14:12];
   assign is_m    = (insn[6:0] == 7'b0110011) && (insn[31:25] == 7'b0000001);
   assign is_mul  = is_m && !f3_in[2];
   assign is_div  = is_m && f3_in[2] && (ENABLE_DIV != 0);
   assign accept  = (state == S_IDLE) && armed && pcpi.pcpi_valid && (is_mul || is_div);
   assign unused_insn = &{1'b0, insn[24:15], insn[11:7]};

   // MULH and MULHSU sign-extend rs1; only MULH sign-extends rs2.
   assign a_sx    = f3_in[1] ^ f3_in[0];
   assign b_sx    = (f3_in[1:0] == 2'b01);
   assign div_sgn = !f3_in[0];

   // A signed rs2 contributes -2^XLEN * rs1 beyond its low XLEN bits. By the
   // final cycle mcand has been shifted left by exactly XLEN, so that
   // correction is a single subtraction of mcand.
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   q_res, r_res, result;
   logic [XLEN:0]     trial;

   assign prod   = b_neg ? (acc - mcand) : acc;
   assign q_res  = dvsr_zero ? '1 : neg_if(quo, q_neg);
   assign r_res  = neg_if(rem, r_neg);
   assign result = f3[2] ? (f3[1] ? r_res : q_res)
                         : ((f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

   // Restoring step: trial[XLEN] is the borrow, set when the shifted
   // remainder is smaller than the divisor.
   assign trial  = {rem, quo[XLEN-1]} - {1'b0, dvsr};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= S_IDLE;
         armed   <= 1'b1;
         cnt     <= '0;
         f3      <= '0;
         ready_q <= 1'b0;
         wait_q  <= 1'b0;
         rd_q    <= '0;
      end else begin
         ready_q <= 1'b0;
         // armed only re-arms once the core lets go of valid, so a valid
         // still held after ready cannot relaunch the same instruction.
         if (!pcpi.pcpi_valid)
            armed <= 1'b1;
         else if (accept)
            armed <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state  <= is_mul ? S_MUL : S_DIV;
                  cnt    <= is_mul ? CNT_W'(MUL_N) : CNT_W'(XLEN);
                  f3     <= f3_in;
                  wait_q <= 1'b1;
               end
            end
            S_MUL, S_DIV: begin
               if (!pcpi.pcpi_valid) begin
                  state  <= S_IDLE;
                  wait_q <= 1'b0;
               end else if (cnt == '0) begin
                  state   <= S_DONE;
                  wait_q  <= 1'b0;
                  ready_q <= 1'b1;
                  rd_q    <= result;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         acc       <= '0;
         mcand     <= {{XLEN{a_sx & rs1[XLEN-1]}}, rs1};
         mplier    <= rs2;
         b_neg     <= b_sx & rs2[XLEN-1];
         rem       <= '0;
         quo       <= neg_if(rs1, div_sgn & rs1[XLEN-1]);
         dvsr      <= neg_if(rs2, div_sgn & rs2[XLEN-1]);
         q_neg     <= div_sgn & (rs1[XLEN-1] ^ rs2[XLEN-1]);
         r_neg     <= div_sgn & rs1[XLEN-1];
         dvsr_zero <= (rs2 == '0);
      end else if (state == S_MUL && cnt != '0) begin
         acc    <= acc + mul_chunk(mcand, mplier[MUL_STEP-1:0]);
         mcand  <= mcand << MUL_STEP;
         mplier <= mplier >> MUL_STEP;
      end else if (state == S_DIV && cnt != '0) begin
         if (!trial[XLEN]) begin
            rem <= trial[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b1};
         end else begin
            rem <= {rem[XLEN-2:0], quo[XLEN-1]};
            quo <= {quo[XLEN-2:0], 1'b0};
         end
      end
   end

   assign pcpi.pcpi_ready = ready_q;
   assign pcpi.pcpi_wr    = ready_q;
   assign pcpi.pcpi_wait  = wait_q;
   assign pcpi.pcpi_rd    = rd_q;
endmodule

// File: tb/tb_pcpi_muldiv_iter.sv
// ---------------------------------------------------------------------------
// tb_pcpi_muldiv_iter
// Four co-processor instances share one stimulus stream:
//   0: MUL_STEP=4 with divide, 1: MUL_STEP=1, 2: MUL_STEP=2, 3: MUL_STEP=8
//   without divide. A cycle-level reference (arithmetic result plus latency
//   countdown) is compared against every output of every instance on each
//   falling edge; directed vectors also pin instance 0's result and each
//   instance's latency to hand-computed constants.
// ---------------------------------------------------------------------------
module tb_pcpi_muldiv_iter;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        valid = 1'b0;
   logic [31:0] insn = '0;
   logic [31:0] rs1 = '0;
   logic [31:0] rs2 = '0;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pcpi_muldiv_iter_if #(.XLEN(32)) bus[4] ();

   logic        o_wait[4];
   logic        o_ready[4];
   logic        o_wr[4];
   logic [31:0] o_rd[4];

   for (genvar g = 0; g < 4; g++) begin : g_bus
      assign bus[g].pcpi_valid = valid;
      assign bus[g].pcpi_insn  = insn;
      assign bus[g].pcpi_rs1   = rs1;
      assign bus[g].pcpi_rs2   = rs2;
      assign o_wait[g]  = bus[g].pcpi_wait;
      assign o_ready[g] = bus[g].pcpi_ready;
      assign o_wr[g]    = bus[g].pcpi_wr;
      assign o_rd[g]    = bus[g].pcpi_rd;
   end

   pcpi_muldiv_iter #(.XLEN(32), .MUL_STEP(4), .ENABLE_DIV(1)) dut0 (.clk(clk), .resetn(resetn), .pcpi(bus[0]));
   pcpi_muldiv_iter #(.XLEN(32), .MUL_STEP(1), .ENABLE_DIV(1)) dut1 (.clk(clk), .resetn(resetn), .pcpi(bus[1]));
   pcpi_muldiv_iter #(.XLEN(32), .MUL_STEP(2), .ENABLE_DIV(1)) dut2 (.clk(clk), .resetn(resetn), .pcpi(bus[2]));
   pcpi_muldiv_iter #(.XLEN(32), .MUL_STEP(8), .ENABLE_DIV(0)) dut3 (.clk(clk), .resetn(resetn), .pcpi(bus[3]));

   function automatic int step_of(input int i);
      case (i)
         0: return 4;
         1: return 1;
         2: return 2;
         default: return 8;
      endcase
   endfunction

   function automatic bit div_en(input int i);
      return (i != 3);
   endfunction

   function automatic bit hit(input int i, input logic [31:0] w);
      return (w[6:0] == 7'h33) && (w[31:25] == 7'h01) && (!w[14] || div_en(i));
   endfunction

   // Cycles from the accepting edge to the edge that raises ready.
   function automatic int model_lat(input int i, input logic [31:0] w);
      return (w[14] ? 32 : 32 / step_of(i)) + 1;
   endfunction

   function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (f3)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
         3'd5: begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
         3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
         default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
      endcase
   endfunction

   function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
      return {f7, 5'd12, 5'd11, f3, 5'd10, 7'b0110011};
   endfunction

   // Reference state per instance.
   logic        m_armed[4];
   logic        m_busy[4];
   int          m_left[4];
   logic [31:0] m_res[4];
   logic        m_wait[4];
   logic        m_ready[4];
   logic [31:0] m_rd[4];

   always @(posedge clk or negedge resetn) begin
      for (int i = 0; i < 4; i++) begin
         if (!resetn) begin
            m_armed[i] <= 1'b1;
            m_busy[i]  <= 1'b0;
            m_left[i]  <= 0;
            m_res[i]   <= '0;
            m_wait[i]  <= 1'b0;
            m_ready[i] <= 1'b0;
            m_rd[i]    <= '0;
         end else begin
            if (m_ready[i]) begin
               m_ready[i] <= 1'b0;
            end else if (m_busy[i]) begin
               if (!valid) begin
                  m_busy[i] <= 1'b0;
                  m_wait[i] <= 1'b0;
               end else if (m_left[i] == 1) begin
                  m_busy[i]  <= 1'b0;
                  m_wait[i]  <= 1'b0;
                  m_ready[i] <= 1'b1;
                  m_rd[i]    <= m_res[i];
               end else begin
                  m_left[i] <= m_left[i] - 1;
               end
            end else if (m_armed[i] && valid && hit(i, insn)) begin
               m_busy[i]  <= 1'b1;
               m_wait[i]  <= 1'b1;
               m_left[i]  <= model_lat(i, insn);
               m_res[i]   <= ref_result(insn[14:12], rs1, rs2);
               m_armed[i] <= 1'b0;
            end
            if (!valid) m_armed[i] <= 1'b1;
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   int          pulses[4] = '{0, 0, 0, 0};
   int          rdy_cyc[4];
   logic [31:0] rdy_val[4];

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         check($sformatf("wait[%0d]", i),  {31'b0, o_wait[i]},  {31'b0, m_wait[i]});
         check($sformatf("ready[%0d]", i), {31'b0, o_ready[i]}, {31'b0, m_ready[i]});
         check($sformatf("wr[%0d]", i),    {31'b0, o_wr[i]},    {31'b0, m_ready[i]});
         check($sformatf("rd[%0d]", i),    o_rd[i],             m_rd[i]);
         if (o_ready[i] === 1'b1) begin
            pulses[i]++;
            rdy_cyc[i] = cyc;
            rdy_val[i] = o_rd[i];
         end
      end
   end

   // Hand-computed latency (accept to ready) for each instance.
   function automatic int lit_lat(input int i, input bit is_div);
      if (is_div) return 33;
      case (i)
         0: return 9;
         1: return 33;
         2: return 17;
         default: return 5;
      endcase
   endfunction

   task automatic run_op(input string nm, input logic [31:0] w, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp0, input int hold,
                         input bit completes);
      int base[4];
      int e0;
      int want;
      for (int i = 0; i < 4; i++) base[i] = pulses[i];
      @(posedge clk); #1;
      valid = 1'b1; insn = w; rs1 = a; rs2 = b;
      e0 = cyc + 1;
      repeat (hold) @(posedge clk);
      #1 valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         want = (completes && hit(i, w)) ? 1 : 0;
         check($sformatf("%s pulses[%0d]", nm, i), pulses[i] - base[i], want);
         if (want == 1 && pulses[i] - base[i] == 1) begin
            check($sformatf("%s latency[%0d]", nm, i), rdy_cyc[i] - e0, lit_lat(i, w[14]));
            if (i == 0) check($sformatf("%s result", nm), rdy_val[0], exp0);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset wait",  {31'b0, o_wait[0]},  32'd0);
      check("reset ready", {31'b0, o_ready[0]}, 32'd0);
      check("reset rd",    o_rd[0],             32'd0);
      resetn = 1'b1;

      run_op("MUL 3*7",         mk(7'h01, 3'd0), 32'd3,        32'd7,        32'h00000015, 40, 1'b1);
      run_op("MULH -10*-4",     mk(7'h01, 3'd1), 32'hFFFFFFF6, 32'hFFFFFFFC, 32'h00000000, 40, 1'b1);
      run_op("MULHSU -10*4",    mk(7'h01, 3'd2), 32'hFFFFFFF6, 32'd4,        32'hFFFFFFFF, 40, 1'b1);
      run_op("MULHU max*max",   mk(7'h01, 3'd3), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 40, 1'b1);
      run_op("MUL 1000*1000",   mk(7'h01, 3'd0), 32'd1000,     32'd1000,     32'h000F4240, 40, 1'b1);
      run_op("MULH min*min",    mk(7'h01, 3'd1), 32'h80000000, 32'h80000000, 32'h40000000, 40, 1'b1);
      run_op("MULHSU -1*max",   mk(7'h01, 3'd2), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 40, 1'b1);
      run_op("DIV -7/2",        mk(7'h01, 3'd4), 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 40, 1'b1);
      run_op("REM -7/2",        mk(7'h01, 3'd6), 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 40, 1'b1);
      run_op("DIVU 100/7",      mk(7'h01, 3'd5), 32'd100,      32'd7,        32'h0000000E, 40, 1'b1);
      run_op("REMU 100/7",      mk(7'h01, 3'd7), 32'd100,      32'd7,        32'h00000002, 40, 1'b1);
      run_op("DIVU 5/0",        mk(7'h01, 3'd5), 32'd5,        32'd0,        32'hFFFFFFFF, 40, 1'b1);
      run_op("REMU 5/0",        mk(7'h01, 3'd7), 32'd5,        32'd0,        32'h00000005, 40, 1'b1);
      run_op("DIV ovf",         mk(7'h01, 3'd4), 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 40, 1'b1);
      run_op("REM ovf",         mk(7'h01, 3'd6), 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 40, 1'b1);
      run_op("DIV -7/0",        mk(7'h01, 3'd4), 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 40, 1'b1);
      run_op("REM -7/0",        mk(7'h01, 3'd6), 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 40, 1'b1);
      run_op("DIV 7/-2",        mk(7'h01, 3'd4), 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 40, 1'b1);
      run_op("REM 7/-2",        mk(7'h01, 3'd6), 32'd7,        32'hFFFFFFFE, 32'h00000001, 40, 1'b1);

      run_op("MUL abort",       mk(7'h01, 3'd0), 32'd9,        32'd9,        32'h00000000, 3,  1'b0);
      run_op("MUL after abort", mk(7'h01, 3'd0), 32'd3,        32'd7,        32'h00000015, 40, 1'b1);
      run_op("no claim f7=0",   mk(7'h00, 3'd0), 32'd3,        32'd7,        32'h00000000, 40, 1'b1);

      // Reset asserted between clock edges in the middle of a divide.
      @(posedge clk); #1;
      valid = 1'b1; insn = mk(7'h01, 3'd5); rs1 = 32'd1234; rs2 = 32'd5;
      repeat (10) @(posedge clk);
      #2 resetn = 1'b0; valid = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("async rst wait[%0d]", i),  {31'b0, o_wait[i]},  32'd0);
         check($sformatf("async rst ready[%0d]", i), {31'b0, o_ready[i]}, 32'd0);
         check($sformatf("async rst rd[%0d]", i),    o_rd[i],             32'd0);
      end
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;

      run_op("REMU after reset", mk(7'h01, 3'd7), 32'd1234,    32'd5,        32'h00000004, 40, 1'b1);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/pcpi_muldiv_iter.md
Name: pcpi_muldiv_iter

Overview:
Parametrised iterative multiply/divide co-processor on the PCPI bus, the successor to the fixed single-rate multiplier. Executes RV32M MUL/MULH/MULHSU/MULHU and, when enabled, DIV/DIVU/REM/REMU. Multiply retires MUL_STEP bits per cycle; divide uses a 1-bit-per-cycle restoring divider. Sits beside the core as a PCPI slave and claims only M-extension instructions.

Parameters:
XLEN, 32, operand/result width; must be a multiple of MUL_STEP
MUL_STEP, 4, multiplier bits consumed per cycle; legal values 1, 2, 4, 8
ENABLE_DIV, 1, 1 = claim and execute funct3 100-111; 0 = never claim them

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  reset, asynchronous, active-low
pcpi_valid  in  1  core presents an instruction
pcpi_insn  in  32  instruction word
pcpi_rs1  in  XLEN  operand 1
pcpi_rs2  in  XLEN  operand 2
pcpi_wr  out  1  result write-back strobe, identical to pcpi_ready
pcpi_rd  out  XLEN  result, valid while pcpi_ready=1
pcpi_wait  out  1  instruction claimed, result pending
pcpi_ready  out  1  one-cycle completion pulse

Behaviour:
- Reset (resetn low, asynchronous): state IDLE, armed=1; pcpi_wr, pcpi_ready, pcpi_wait = 0; pcpi_rd = 0. Reset mid-operation drops the operation silently.
- Decode: opcode[6:0]=0110011 and funct7[31:25]=0000001. funct3 000-011 is multiply; 100-111 is divide, only when ENABLE_DIV=1. Any other insn is never claimed: no wait, no ready.
- Accept: in IDLE with armed=1, pcpi_valid=1 and decode hit, at edge E0 latch operands and funct3 and clear armed. pcpi_wait=1 from the cycle after E0 until the ready cycle.
- armed is set at any edge where pcpi_valid=0. This blocks re-launch while the core still holds valid after ready.
- States: IDLE -> MUL (N=XLEN/MUL_STEP cycles) or DIV (N=XLEN cycles) -> DONE (1 cycle) -> IDLE.
- In DONE: pcpi_ready=pcpi_wr=1 and pcpi_wait=0. Ready is high in the cycle after edge E0+N+1, for exactly one cycle.
- pcpi_rd is registered and holds its last value outside ready.
- If pcpi_valid falls while in MUL/DIV: abort to IDLE at that edge, wait drops, no ready.
- Multiply:
  - rs1 is sign-extended for MULH/MULHSU; rs2 is sign-extended for MULH only. Operands are extended to XLEN+1 bits.
  - 2*XLEN accumulator, shift-add of MUL_STEP bits per cycle.
  - MUL returns product[XLEN-1:0]; the others return product[2*XLEN-1:XLEN].
- Divide:
  - Signed ops take magnitudes and fix signs at the end. Quotient is negative iff signs differ; remainder takes the dividend's sign.
  - Divide by zero: quotient = all ones; remainder = rs1. Applies to both signed and unsigned ops.
  - Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1): quotient = rs1, remainder = 0.
  - Both special cases still take the full N-cycle latency, so latency is data-independent.
- Accept and abort never coincide: accept requires IDLE.

Test Plan:
1. XLEN=32, MUL_STEP=4; MUL 3*7 -> rd=21. MULH -10*-4 -> rd=0. MULHSU -10*4 -> rd=FFFFFFFF. MULHU FFFFFFFF*FFFFFFFF -> rd=FFFFFFFE. Ready exactly 1 cycle, wr=ready, wait high for the 9 cycles before ready.
2. Latency sweep with MUL_STEP=1, 2, 8 on MUL 1000*1000 -> rd=000F4240. Ready appears 33 / 17 / 5 cycles after accept respectively.
3. Divide: DIV -7/2 -> FFFFFFFD. REM -7/2 -> FFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. Each has ready 33 cycles after accept.
4. Corners: DIVU 5/0 -> FFFFFFFF. REMU 5/0 -> 5. DIV 80000000/FFFFFFFF -> 80000000. REM of the same -> 0.
5. Control:
   - Valid held 1 cycle past ready -> no second launch.
   - Valid dropped mid-MUL -> wait falls, no ready; the next op completes correctly.
   - resetn pulsed low mid-DIV -> all outputs 0 asynchronously.
6. Non-claim: funct7=0000000, or ENABLE_DIV=0 with a DIV insn, valid held 40 cycles -> wait and ready stay 0.
